// File: rtl/apb_master.sv
// APB requester: one command at a time into SETUP/ACCESS, optional ACCESS watchdog under APB_MASTER_TIMEOUT_EN.
// Latency: accept at edge N, SETUP N+1, ACCESS N+2, rsp_valid pulse one cycle after the ACCESS cycle with pready (N+3 at zero waits).
// Backpressure: cmd_ready is high only in IDLE; no command buffering, the requester holds cmd_valid until accepted.
module apb_master #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic [DATA_WIDTH-1:0] prdata
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   timeout_hit;
    logic   access_done;

    // ACCESS ends either on the completer's pready or on the watchdog firing.
    assign access_done = (state == ST_ACCESS) && (pready || timeout_hit);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] to_cnt;

    // Counter value k means k stalled ACCESS cycles already seen; the limit is
    // reached by the stall in progress when the count sits one below it.
    assign timeout_hit = (state == ST_ACCESS) && !pready &&
                         (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            if (state == ST_SETUP) begin
                to_cnt <= '0;
            end else if ((state == ST_ACCESS) && !pready) begin
                to_cnt <= to_cnt + 1'b1;
            end
            rsp_timeout <= timeout_hit;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_hit        = 1'b0;
    assign rsp_timeout        = 1'b0;
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready || timeout_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready = (state == ST_IDLE);
    end

    // APB strobes are registered from the next state so they line up with the FSM phase.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            psel      <= (state_nxt != ST_IDLE);
            penable   <= (state_nxt == ST_ACCESS);
            rsp_valid <= access_done;
            if ((state == ST_IDLE) && cmd_valid) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_write ? cmd_wdata : '0;
            end
            if ((state == ST_ACCESS) && pready && !pwrite) begin
                rsp_rdata <= prdata;
            end
        end
    end

endmodule
